decompose_rx: RTL and testbench

Receive-side frame parser for the measurement link. Accepts a byte stream, synchronises on a header byte and assembles 8 payload bytes into one 64-bit word. Splits the word into the high-time count, total-time count and frequency fields, laid out exactly as the transmit side packs them. Sits behind the byte receiver (UART/serial front end) and presents held, registered fields plus a one-cycle strobe to downstream display/processing logic.

---
 rtl/decompose_rx.sv | 171 +++++++++++++++++
 tb/tb_decompose_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decompose_rx.sv
// rtl/decompose_rx.sv - header-synced 8-byte frame parser splitting payload into high/all/fx fields
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module decompose_rx #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [63:0] data64,
  output logic [15:0] high_times,
  output logic [15:0] all_times,
  output logic [31:0] fx,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int unsigned GAP_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1
`ifdef CHECKSUM_EN
    ,
    S_CHECK   = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic [63:0]      r_shift;
  logic [GAP_W-1:0] r_gap;
  logic             w_start;
  logic             w_shift;
  logic             w_commit;
  logic             w_err;
  logic             w_timeout;
  logic [63:0]      w_shift_next;
  logic [63:0]      w_commit_data;

`ifdef CHECKSUM_EN
  logic [7:0]       r_xor;
`endif

  assign w_shift_next = {r_shift[55:0], rx_data};
  // Expiry only when no byte arrives on the same cycle; a late byte still wins.
  assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_gap == GAP_MAX);

`ifdef CHECKSUM_EN
  assign w_commit_data = r_shift;
`else
  assign w_commit_data = w_shift_next;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == HEADER)) begin
          w_next_state = S_PAYLOAD;
          w_start      = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          w_shift = 1'b1;
          if (r_cnt == 3'd7) begin
`ifdef CHECKSUM_EN
            w_next_state = S_CHECK;
`else
            w_next_state = S_IDLE;
            w_commit     = 1'b1;
`endif
          end
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
          w_err        = 1'b1;
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          w_next_state = S_IDLE;
          if (rx_data == r_xor) begin
            w_commit = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
          w_err        = 1'b1;
        end
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_shift <= 64'd0;
      r_gap   <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= 3'd0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_shift) begin
        r_shift <= w_shift_next;
      end
      if ((r_state == S_IDLE) || rx_valid || w_timeout) begin
        r_gap <= '0;
      end else begin
        r_gap <= r_gap + GAP_W'(1);
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor <= 8'd0;
    end else if (w_start) begin
      r_xor <= 8'd0;
    end else if (w_shift) begin
      r_xor <= r_xor ^ rx_data;
    end
  end
`endif

  // Outputs change only on a whole good frame; errors leave them untouched.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data64      <= 64'd0;
      high_times  <= 16'd0;
      all_times   <= 16'd0;
      fx          <= 32'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= w_commit;
      frame_err   <= w_err;
      if (w_commit) begin
        data64     <= w_commit_data;
        high_times <= w_commit_data[63:48];
        all_times  <= w_commit_data[47:32];
        fx         <= w_commit_data[31:0];
      end
    end
  end

endmodule

// File: tb/tb_decompose_rx.sv
// tb/tb_decompose_rx.sv - scoreboard bench for decompose_rx against a byte-list frame model
// Builds with or without CHECKSUM_EN; TIMEOUT overridden to 16.
module tb_decompose_rx;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int TO = 16;
`ifdef CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [63:0] data64;
  logic [15:0] high_times;
  logic [15:0] all_times;
  logic [31:0] fx;
  logic        frame_valid;
  logic        frame_err;

  decompose_rx #(.HEADER(HDR), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .data64(data64), .high_times(high_times), .all_times(all_times), .fx(fx),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [63:0] data;
    int          stamp;
  } exp_t;

  exp_t       exp_q[$];
  bit         m_in = 1'b0;
  logic [7:0] m_bytes[$];
  int         m_last = 0;
  logic [63:0] m_out = 64'd0;
  bit         done = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  // Frame model: collect bytes after a header, decide on the last one; edge e is when the byte is sampled.
  function automatic void model_step(input bit v, input logic [7:0] b, input int e);
    logic [63:0] w;
    logic [7:0]  x;
    exp_t        r;
    if (v) begin
      if (!m_in) begin
        if (b == HDR) begin
          m_in = 1'b1;
          m_bytes.delete();
          m_last = e;
        end
      end else begin
        m_bytes.push_back(b);
        m_last = e;
        if (m_bytes.size() == (CK ? 9 : 8)) begin
          w = 64'd0;
          x = 8'd0;
          for (int i = 0; i < 8; i++) begin
            w = (w << 8) | 64'(m_bytes[i]);
            x = x ^ m_bytes[i];
          end
          if (CK && (m_bytes[8] != x)) begin
            r = '{1'b1, m_out, e};
          end else begin
            m_out = w;
            r = '{1'b0, w, e};
          end
          exp_q.push_back(r);
          m_in = 1'b0;
        end
      end
    end else if (m_in && (e - m_last == TO)) begin
      r = '{1'b1, m_out, e};
      exp_q.push_back(r);
      m_in = 1'b0;
    end
  endfunction

  task automatic step(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(posedge sys_clk);
    #1;
    model_step(v, b, cyc);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [63:0] p, input bit bad_ck, input int maxgap);
    logic [7:0] x;
    logic [7:0] bt;
    x = 8'd0;
    step(1'b1, HDR);
    for (int i = 0; i < 8; i++) begin
      bt = p[63-8*i -: 8];
      x  = x ^ bt;
      if (maxgap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(0, maxgap));
      step(1'b1, bt);
    end
    if (CK) step(1'b1, x ^ {7'd0, bad_ck});
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // Monitor: the only process that counts; pops the scoreboard whenever a pulse appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("rst_data64", data64, 64'd0);
        chk("rst_fields", {high_times, all_times, fx}, 64'd0);
        chk("rst_pulses", {62'd0, frame_valid, frame_err}, 64'd0);
      end else begin
        if (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
          e = exp_q.pop_front();
          chk("missing_pulse_stamp", 64'(cyc), 64'(e.stamp));
        end
        if (frame_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {62'd0, frame_valid, frame_err}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {62'd0, frame_valid, frame_err}, e.is_err ? 64'd1 : 64'd2);
            chk("pulse_cycle", 64'(cyc), 64'(e.stamp));
            chk("data64", data64, e.data);
            chk("high_times", 64'(high_times), 64'(e.data[63:48]));
            chk("all_times", 64'(all_times), 64'(e.data[47:32]));
            chk("fx", 64'(fx), 64'(e.data[31:0]));
          end
        end
        if (done) begin
          chk("pending_expect", 64'(exp_q.size()), 64'd0);
          chk("final_data64", data64, m_out);
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $finish;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    idle(2);

    send_frame(64'h123456789ABCDEF0, 1'b0, 0);
    idle(3);
    if (CK) begin
      send_frame(64'h123456789ABCDEF0, 1'b1, 0);
      idle(3);
    end

    step(1'b1, 8'h00); step(1'b1, 8'hFF); step(1'b1, 8'h3C);
    send_frame(64'h1122A54455667788, 1'b0, 0);
    idle(2);

    step(1'b1, HDR); step(1'b1, 8'h11); step(1'b1, 8'h22);
    idle(20);
    send_frame(64'h0102030405060708, 1'b0, 0);
    idle(2);

    step(1'b1, HDR); step(1'b1, 8'h11); step(1'b1, 8'h22);
    idle(TO - 1);
    for (int i = 0; i < (CK ? 7 : 6); i++) step(1'b1, 8'h30 + 8'(i));
    idle(2);

    step(1'b1, HDR);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hE0 + 8'(i));
    rx_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_in  = 1'b0;
    m_out = 64'd0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    send_frame(64'hCAFEBABE00C0FFEE, 1'b0, 0);

    send_frame(64'hAAAA5555DEADBEEF, 1'b0, 0);
    send_frame(64'h0F0E0D0C0B0A0908, 1'b0, 0);
    idle(2);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom));
      p = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) p[39:32] = HDR;
      send_frame(p, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0) ? TO + 3 : 2);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 4));
    end

    idle(TO + 4);
    done = 1'b1;
  end

endmodule
